add_sub_pipe: RTL and testbench

//  Parametrised two-stage pipelined add/subtract unit with a result buffer; successor to the single-shot ALU adder.

---
 rtl/add_sub_pipe.sv | 181 ++++++++++++++++++
 tb/tb_add_sub_pipe.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/add_sub_pipe.sv
// add_sub_pipe: two-stage pipelined add/subtract unit with a circular result buffer.
//
// Operations (op): 00 ADD a+b, 01 ADC a+b+c_in, 10 SUB a+~b+1, 11 SBB a+~b+c_in.
// c_out is bit DATA_SIZE of the extended sum (1 = no borrow for SUB/SBB); ovf is signed overflow.
//
// Stage S1 captures the operation on accept. S2 holds the computed sum/flags/id. Each valid
// S2 entry is written into the result buffer on the following edge. Ops are admitted only while
// buffered + in-flight work is below RES_DEPTH, so the buffer never overflows and the pipeline
// never stalls.
//
// Optional feature: define ADD_SUB_SATURATE_EN to clamp the sum to signed max/min on overflow
// (flags unchanged). Without it the sum wraps and no clamp logic is built.
//
// Ports:
//   clk, rst_n                   clock (rising edge), asynchronous active-low reset
//   a_valid_data / a_ready_data  operand handshake from IN_ALU
//   add_1, add_2, id_add, c_in   operands, transaction ID, carry/borrow-in
//   op                           operation select
//   a_valid_res / ready_f_res    result handshake towards OUT_ALU
//   result_add                   buffer head {id, ovf, c_out, sum}
//   res_count                    number of buffered results
module add_sub_pipe #(
  parameter int unsigned DATA_SIZE = 16,
  parameter int unsigned ID_SIZE   = 4,
  parameter int unsigned RES_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              a_valid_data,
  output logic                              a_ready_data,
  input  logic [DATA_SIZE-1:0]              add_1,
  input  logic [DATA_SIZE-1:0]              add_2,
  input  logic [ID_SIZE-1:0]                id_add,
  input  logic                              c_in,
  input  logic [1:0]                        op,
  output logic                              a_valid_res,
  input  logic                              ready_f_res,
  output logic [DATA_SIZE+2+ID_SIZE-1:0]    result_add,
  output logic [$clog2(RES_DEPTH):0]        res_count
);

  localparam int unsigned ResW = DATA_SIZE + 2 + ID_SIZE;
  localparam int unsigned PtrW = $clog2(RES_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW:0] DepthW = (CntW + 1)'(RES_DEPTH);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(RES_DEPTH - 1);

  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpSub = 2'b10;

  // ---------------------------------------------------------------- S1
  logic                 accept;
  logic                 s1_valid_q;
  logic [1:0]           s1_op_q;
  logic [DATA_SIZE-1:0] s1_a_q, s1_b_q;
  logic [ID_SIZE-1:0]   s1_id_q;
  logic                 s1_cin_q;

  assign accept = a_valid_data & a_ready_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_id_q    <= '0;
      s1_cin_q   <= 1'b0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_op_q  <= op;
        s1_a_q   <= add_1;
        s1_b_q   <= add_2;
        s1_id_q  <= id_add;
        s1_cin_q <= c_in;
      end
    end
  end

  // Arithmetic on S1 contents
  logic [DATA_SIZE-1:0] b_eff;
  logic                 cin_eff;
  logic [DATA_SIZE:0]   sum_ext;
  logic                 ovf;
  logic [DATA_SIZE-1:0] sum_d;

  always_comb begin
    b_eff   = s1_op_q[1] ? ~s1_b_q : s1_b_q;
    cin_eff = s1_cin_q;
    case (s1_op_q)
      OpAdd:   cin_eff = 1'b0;
      OpSub:   cin_eff = 1'b1;
      default: cin_eff = s1_cin_q;
    endcase
    sum_ext = {1'b0, s1_a_q} + {1'b0, b_eff} + {{DATA_SIZE{1'b0}}, cin_eff};
    ovf     = (s1_a_q[DATA_SIZE-1] == b_eff[DATA_SIZE-1]) &
              (sum_ext[DATA_SIZE-1] != s1_a_q[DATA_SIZE-1]);
    sum_d   = sum_ext[DATA_SIZE-1:0];
`ifdef ADD_SUB_SATURATE_EN
    // Overflow direction follows operand A's sign: positive operands saturate high.
    if (ovf) begin
      sum_d = s1_a_q[DATA_SIZE-1] ? {1'b1, {(DATA_SIZE-1){1'b0}}}
                                  : {1'b0, {(DATA_SIZE-1){1'b1}}};
    end
`endif
  end

  // ---------------------------------------------------------------- S2
  logic                 s2_valid_q;
  logic [DATA_SIZE-1:0] s2_sum_q;
  logic                 s2_c_q, s2_ovf_q;
  logic [ID_SIZE-1:0]   s2_id_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_sum_q   <= '0;
      s2_c_q     <= 1'b0;
      s2_ovf_q   <= 1'b0;
      s2_id_q    <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_sum_q <= sum_d;
        s2_c_q   <= sum_ext[DATA_SIZE];
        s2_ovf_q <= ovf;
        s2_id_q  <= s1_id_q;
      end
    end
  end

  // ---------------------------------------------------------------- result buffer
  logic [ResW-1:0] mem_q [RES_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            push, pop;

  assign push = s2_valid_q;
  assign pop  = a_valid_res & ready_f_res;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(RES_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {s2_id_q, s2_ovf_q, s2_c_q, s2_sum_q};
        wr_ptr_q        <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

  // Credit ignores a same-cycle pop on purpose; it keeps the ready path off ready_f_res.
  logic [CntW:0] outstanding;
  assign outstanding = {1'b0, count_q} + {{CntW{1'b0}}, s1_valid_q}
                     + {{CntW{1'b0}}, s2_valid_q};

  assign a_ready_data = rst_n & (outstanding < DepthW);
  assign a_valid_res  = (count_q != '0);
  assign result_add   = mem_q[rd_ptr_q];
  assign res_count    = count_q;

endmodule

// File: tb/tb_add_sub_pipe.sv
// Self-checking bench for add_sub_pipe (DATA_SIZE=16, ID_SIZE=4, RES_DEPTH=4).
// A scoreboard queue holds the expected result of every accepted op; readiness is predicted
// from the number of accepted-but-not-yet-taken results.
module tb_add_sub_pipe;

  localparam int DW = 16;
  localparam int IW = 4;
  localparam int DEPTH = 4;
  localparam int RW = DW + 2 + IW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_valid_data;
  logic          a_ready_data;
  logic [DW-1:0] add_1, add_2;
  logic [IW-1:0] id_add;
  logic          c_in;
  logic [1:0]    op;
  logic          a_valid_res;
  logic          ready_f_res;
  logic [RW-1:0] result_add;
  logic [2:0]    res_count;

  add_sub_pipe #(.DATA_SIZE(DW), .ID_SIZE(IW), .RES_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .a_valid_data (a_valid_data),
    .a_ready_data (a_ready_data),
    .add_1        (add_1),
    .add_2        (add_2),
    .id_add       (id_add),
    .c_in         (c_in),
    .op           (op),
    .a_valid_res  (a_valid_res),
    .ready_f_res  (ready_f_res),
    .result_add   (result_add),
    .res_count    (res_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [RW-1:0] exp_q[$];
  int            outstanding = 0;
  logic [RW-1:0] last_pop;
  bit            last_acc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operation's meaning.
  function automatic logic [RW-1:0] ref_res(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic ci, input logic [1:0] o,
                                            input logic [IW-1:0] id);
    int unsigned bb, cc, s;
    int          sf;
    logic [DW-1:0] b16, sum;
    logic          c, v;
    bb  = o[1] ? (32'hFFFF - 32'(b)) : 32'(b);
    cc  = (o == 2'b00) ? 0 : (o == 2'b10) ? 1 : 32'(ci);
    s   = 32'(a) + bb + cc;
    c   = (s >= 32'h10000);
    sum = DW'(s);
    b16 = DW'(bb);
    sf  = int'($signed(a)) + int'($signed(b16)) + int'(cc);
    v   = (sf > 32767) || (sf < -32768);
`ifdef ADD_SUB_SATURATE_EN
    if (sf > 32767) sum = 16'h7FFF;
    else if (sf < -32768) sum = 16'h8000;
`endif
    return {id, v, c, sum};
  endfunction

  // One clock: sample at the falling edge, update the model, return 1 after the rising edge.
  task automatic step();
    bit acc, pop;
    @(negedge clk);
    acc = a_valid_data & a_ready_data;
    pop = a_valid_res & ready_f_res;
    check("ready", a_ready_data, 64'(rst_n && (outstanding < DEPTH)));
    if (pop) begin
      if (exp_q.size() == 0) begin
        check("pop_empty", 64'(exp_q.size()), 64'd1);
      end else begin
        last_pop = result_add;
        check("result", result_add, exp_q.pop_front());
        outstanding--;
      end
    end
    if (acc) begin
      exp_q.push_back(ref_res(add_1, add_2, c_in, op, id_add));
      outstanding++;
    end
    last_acc = acc;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic ci,
                        input logic [1:0] o, input logic [IW-1:0] id);
    add_1 = a; add_2 = b; c_in = ci; op = o; id_add = id;
  endtask

  task automatic drain(input string tag);
    a_valid_data = 1'b0;
    ready_f_res  = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic ci, input logic [1:0] o, input logic [IW-1:0] id,
                        input logic [RW-1:0] exp);
    ready_f_res  = 1'b1;
    set_op(a, b, ci, o, id);
    a_valid_data = 1'b1;
    step();
    check("accept", 64'(last_acc), 64'd1);
    a_valid_data = 1'b0;
    check("lat_n", a_valid_res, 1'b0);
    step();
    check("lat_n1", a_valid_res, 1'b0);
    drain("drain");
    check(tag, last_pop, exp);
  endtask

  function automatic logic [DW-1:0] rnd_data();
    int unsigned r;
    r = $urandom_range(0, 7);
    case (r)
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h7FFF;
      3: return 16'h8000;
      default: return DW'($urandom);
    endcase
  endfunction

  int k;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; a_valid_data = 1'b0; ready_f_res = 1'b0;
    set_op('0, '0, 1'b0, 2'b00, '0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid_res", a_valid_res, 1'b0);
    check("rst_count", res_count, 3'd0);
    check("rst_result", result_add, '0);
    check("rst_ready", a_ready_data, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", a_ready_data, 1'b1);

    // Directed arithmetic cases
    run_op("add_carry", 16'hFFFF, 16'h0001, 1'b0, 2'b00, 4'd3, {4'd3, 1'b0, 1'b1, 16'h0000});
    run_op("sub_borrow", 16'h0005, 16'h0007, 1'b0, 2'b10, 4'd1, {4'd1, 1'b0, 1'b0, 16'hFFFE});
    run_op("sbb", 16'h0005, 16'h0003, 1'b0, 2'b11, 4'd2, {4'd2, 1'b0, 1'b1, 16'h0001});
`ifdef ADD_SUB_SATURATE_EN
    run_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 2'b00, 4'd4, {4'd4, 1'b1, 1'b0, 16'h7FFF});
    run_op("sub_ovf_neg", 16'h8000, 16'h0001, 1'b0, 2'b10, 4'd5, {4'd5, 1'b1, 1'b1, 16'h8000});
`else
    run_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 2'b00, 4'd4, {4'd4, 1'b1, 1'b0, 16'h8000});
    run_op("sub_ovf_neg", 16'h8000, 16'h0001, 1'b0, 2'b10, 4'd5, {4'd5, 1'b1, 1'b1, 16'h7FFF});
`endif
    run_op("adc", 16'h1234, 16'h0001, 1'b1, 2'b01, 4'd6, {4'd6, 1'b0, 1'b0, 16'h1236});

    // Back-pressure: six ops offered while OUT_ALU stalls
    ready_f_res = 1'b0;
    k = 0;
    for (int c = 0; c < 10; c++) begin
      set_op(DW'($urandom), DW'($urandom), 1'($urandom), 2'($urandom), IW'(k));
      a_valid_data = (k < 6);
      step();
      if (last_acc) k++;
    end
    check("bp_accepted", 64'(k), 64'd4);
    check("bp_ready", a_ready_data, 1'b0);
    check("bp_count", res_count, 3'd4);
    ready_f_res = 1'b1;
    for (int c = 0; c < 30 && (k < 6 || exp_q.size() != 0); c++) begin
      set_op(DW'($urandom), DW'($urandom), 1'($urandom), 2'($urandom), IW'(k));
      a_valid_data = (k < 6);
      step();
      if (last_acc) k++;
    end
    check("bp_all_accepted", 64'(k), 64'd6);
    drain("bp_drain");

    // Continuous stream: one accept per cycle, IDs wrap 15 -> 0
    ready_f_res = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_op(rnd_data(), rnd_data(), 1'($urandom), 2'($urandom), IW'(i));
      a_valid_data = 1'b1;
      step();
      check("stream_accept", 64'(last_acc), 64'd1);
    end
    drain("stream_drain");

    // Random handshakes on both sides
    for (int i = 0; i < 400; i++) begin
      set_op(rnd_data(), rnd_data(), 1'($urandom), 2'($urandom), IW'($urandom));
      a_valid_data = ($urandom_range(0, 3) != 0);
      ready_f_res  = ($urandom_range(0, 2) != 0);
      step();
    end
    drain("rand_drain");

    // Reset with work in flight and buffered
    ready_f_res = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_op(rnd_data(), rnd_data(), 1'($urandom), 2'($urandom), IW'(i));
      a_valid_data = 1'b1;
      step();
    end
    check("pre_rst_outstanding", 64'(outstanding), 64'd4);
    a_valid_data = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid_res", a_valid_res, 1'b0);
    check("mid_rst_count", res_count, 3'd0);
    check("mid_rst_ready", a_ready_data, 1'b0);
    exp_q.delete();
    outstanding = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    ready_f_res = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("no_stale", a_valid_res, 1'b0);
    check("no_stale_count", res_count, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
